// File: rtl/zigzag_pkg.sv
// Shared types, sizes and the JPEG zigzag scan table for the zigzag block buffer.
package zigzag_pkg;
  localparam int BLOCK_SIZE = 64;
  localparam int VEC_LEN    = 8;
  localparam int ROW_ORDER  = 0;
  localparam int COL_ORDER  = 1;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} rd_state_t;

  // Scan position -> natural (row-major) index within the 8x8 block.
  localparam logic [5:0] ZZ_LUT [BLOCK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [5:0] zz_to_natural(input logic [5:0] zz);
    return ZZ_LUT[zz];
  endfunction
endpackage

// File: rtl/zz_bank_store.sv
// Coefficient RAM for all banks plus per-bank written-masks; one write port and
// an 8-wide read port whose unwritten positions read as zero.
module zz_bank_store
  import zigzag_pkg::*;
#(
  parameter int COEF_W    = 12,
  parameter int NUM_BANKS = 4,
  parameter int COL_MODE  = ROW_ORDER,
  localparam int BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      wr_en,
  input  logic [BANK_W-1:0]         wr_bank,
  input  logic [5:0]                wr_idx,
  input  logic signed [COEF_W-1:0]  wr_data,
  input  logic                      clr_en,
  input  logic [BANK_W-1:0]         clr_bank,
  input  logic [BANK_W-1:0]         rd_bank,
  input  logic [2:0]                rd_vec,
  output logic [VEC_LEN*COEF_W-1:0] rd_data
);
  logic signed [COEF_W-1:0] mem  [NUM_BANKS*BLOCK_SIZE];
  logic [BLOCK_SIZE-1:0]    mask [NUM_BANKS];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= wr_data;
  end

  // The mask alone decides visibility, so releasing a bank never touches the RAM.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int b = 0; b < NUM_BANKS; b++) mask[b] <= '0;
    end else begin
      if (clr_en) mask[clr_bank] <= '0;
      if (wr_en)  mask[wr_bank][wr_idx] <= 1'b1;
    end
  end

  for (genvar j = 0; j < VEC_LEN; j++) begin : g_lane
    logic [5:0] idx;
    if (COL_MODE == COL_ORDER) begin : g_col
      assign idx = {3'(j), rd_vec};
    end else begin : g_row
      assign idx = {rd_vec, 3'(j)};
    end
    assign rd_data[j*COEF_W +: COEF_W] = mask[rd_bank][idx] ? mem[{rd_bank, idx}] : '0;
  end
endmodule

// File: rtl/zigzag_block_buffer.sv
// Scatters (run, value) beats into natural-order 8x8 banks and drains each closed
// bank as eight row or column vectors with ready/valid on both sides.
module zigzag_block_buffer
  import zigzag_pkg::*;
#(
  parameter int COEF_W    = 12,
  parameter int NUM_BANKS = 4,
  parameter int COL_MODE  = ROW_ORDER
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic signed [COEF_W-1:0]  value_in,
  input  logic [5:0]                run_in,
  input  logic                      eob_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic [VEC_LEN*COEF_W-1:0] vector_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic                      last_out,
  output logic                      error_out
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int OCC_W  = BANK_W + 1;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(NUM_BANKS);

  logic [BANK_W-1:0]         wr_ptr, rd_ptr;
  logic [OCC_W-1:0]          occ;
  logic [5:0]                pos;
  logic                      err_q;
  logic [6:0]                t;
  logic                      accept, close, wr_en, rel;
  rd_state_t                 st, st_nxt;
  logic [2:0]                vec_k;
  logic [VEC_LEN*COEF_W-1:0] rd_data, vec_p1;
  logic                      vld_p1, last_p1;

  // Gated by rst_in so the input side reads not-ready for the whole reset window.
  assign ready_out = rst_in && (occ < FULL);
  assign accept    = valid_in && ready_out;
  assign t         = {1'b0, pos} + {1'b0, run_in};
  assign wr_en     = accept && !t[6];
  assign close     = accept && (t[6] || (t == 7'd63) || eob_in);
  assign rel       = (st == PRESENT) && ready_in && (vec_k == 3'd7);

  zz_bank_store #(
    .COEF_W    (COEF_W),
    .NUM_BANKS (NUM_BANKS),
    .COL_MODE  (COL_MODE)
  ) u_store (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .wr_en    (wr_en),
    .wr_bank  (wr_ptr),
    .wr_idx   (zz_to_natural(t[5:0])),
    .wr_data  (value_in),
    .clr_en   (rel),
    .clr_bank (rd_ptr),
    .rd_bank  (rd_ptr),
    .rd_vec   (vec_k),
    .rd_data  (rd_data)
  );

  // Input stage: scan position, write bank, sticky overflow.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pos    <= '0;
      wr_ptr <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      if (t[6]) err_q <= 1'b1;
      if (close) begin
        pos    <= '0;
        wr_ptr <= wr_ptr + BANK_W'(1);
      end else begin
        pos    <= t[5:0] + 6'd1;
      end
    end
  end

  // Occupancy and read bank; a close and a release in one cycle cancel out.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      occ    <= '0;
      rd_ptr <= '0;
    end else begin
      if (rel) rd_ptr <= rd_ptr + BANK_W'(1);
      unique case ({close, rel})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) st <= IDLE;
    else         st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    if (occ != '0) st_nxt = FETCH;
      FETCH:   st_nxt = PRESENT;
      PRESENT: if (ready_in) st_nxt = (vec_k == 3'd7) ? IDLE : FETCH;
      default: st_nxt = IDLE;
    endcase
  end

  // Output stage: vector register held untouched throughout PRESENT until accepted.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vec_p1  <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      vec_k   <= '0;
    end else begin
      if (st == FETCH) begin
        vec_p1  <= rd_data;
        vld_p1  <= 1'b1;
        last_p1 <= (vec_k == 3'd7);
      end else if ((st == PRESENT) && ready_in) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
        vec_k   <= vec_k + 3'd1;
      end
    end
  end

  assign vector_out = vec_p1;
  assign valid_out  = vld_p1;
  assign last_out   = last_p1;
  assign error_out  = err_q;
endmodule
